stream_hsmooth: RTL and testbench

// - Avalon-ST 24-bit RGB video stage directly upstream of the colour-detect image processor.
// - Applies a 3-tap horizontal [1 2 1]/4 smoothing filter per channel to video packets, removing

---
 rtl/stream_hsmooth_if.sv | 10 +
 rtl/stream_hsmooth.sv | 119 +++++++++++
 tb/tb_stream_hsmooth.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/stream_hsmooth_if.sv
// stream_hsmooth_if: 24-bit RGB Avalon-ST bus (data/valid/ready/sop/eop) with master/slave views
interface stream_hsmooth_if;
  logic [23:0] data;
  logic        valid;
  logic        ready;
  logic        sop;
  logic        eop;
  modport master (output data, valid, sop, eop, input ready);
  modport slave  (input data, valid, sop, eop, output ready);
endinterface

// File: rtl/stream_hsmooth.sv
// stream_hsmooth: 3-tap [1 2 1]/4 horizontal RGB smoothing of video packets; optional HSMOOTH_BYPASS_EN adds a per-packet bypass input
module stream_hsmooth #(
  parameter logic [10:0] IMAGE_W = 11'd640
) (
  input logic clk,
  input logic reset,
`ifdef HSMOOTH_BYPASS_EN
  input logic bypass,
`endif
  stream_hsmooth_if.slave  sink,
  stream_hsmooth_if.master source
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] PASS      = 3'd1;
  localparam logic [2:0] VID_FIRST = 3'd2;
  localparam logic [2:0] VID       = 3'd3;
  localparam logic [2:0] FLUSH     = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [23:0] prev_q, prev_d, cur_q, cur_d;
  logic [10:0] x_q, x_d;
  logic        end_q, end_d;
  logic [23:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d, out_sop_q, out_sop_d, out_eop_q, out_eop_d;
  logic        load_ok, sop_block, sink_rdy, acc, is_vid;

  function automatic logic [23:0] f(input logic [23:0] a, input logic [23:0] b, input logic [23:0] c);
    for (int i = 0; i < 3; i++)
      f[8*i+:8] = 8'(({2'b0, a[8*i+:8]} + {1'b0, b[8*i+:8], 1'b0} + {2'b0, c[8*i+:8]} + 10'd2) >> 2);
  endfunction

  assign sink.ready   = sink_rdy;
  assign source.data  = out_data_q;
  assign source.valid = out_valid_q;
  assign source.sop   = out_sop_q;
  assign source.eop   = out_eop_q;

  // Handshake, packet classification, line state machine and output-slot loading
  always_comb begin
    load_ok     = ~out_valid_q | source.ready;
    sop_block   = (state_q == VID) & sink.valid & sink.sop;
    sink_rdy    = load_ok & (state_q != FLUSH) & ~sop_block;
    acc         = sink.valid & sink_rdy;
`ifdef HSMOOTH_BYPASS_EN
    is_vid      = (sink.data[3:0] == 4'h0) & ~bypass;
`else
    is_vid      = sink.data[3:0] == 4'h0;
`endif
    state_d     = state_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    x_d         = x_q;
    end_d       = end_q;
    out_data_d  = out_data_q;
    out_valid_d = load_ok ? 1'b0 : out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    if (acc && (sink.sop || state_q == IDLE || state_q == PASS)) begin
      out_valid_d = 1'b1;
      out_data_d  = sink.data;
      out_sop_d   = sink.sop;
      out_eop_d   = sink.eop;
      if (sink.sop)
        state_d = is_vid ? VID_FIRST : PASS;
      else if (state_q == PASS && sink.eop)
        state_d = IDLE;
    end else if (acc && state_q == VID_FIRST) begin
      prev_d  = sink.data;
      cur_d   = sink.data;
      x_d     = 11'd0;
      end_d   = sink.eop;
      state_d = (sink.eop || IMAGE_W == 11'd1) ? FLUSH : VID;
    end else if (acc && state_q == VID) begin
      out_valid_d = 1'b1;
      out_data_d  = f(prev_q, cur_q, sink.data);
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      prev_d      = cur_q;
      cur_d       = sink.data;
      x_d         = x_q + 11'd1;
      end_d       = sink.eop;
      state_d     = (sink.eop || x_q + 11'd1 == IMAGE_W - 11'd1) ? FLUSH : VID;
    end else if (sop_block) begin
      end_d   = 1'b1;
      state_d = FLUSH;
    end else if (state_q == FLUSH && load_ok) begin
      out_valid_d = 1'b1;
      out_data_d  = f(prev_q, cur_q, cur_q);
      out_sop_d   = 1'b0;
      out_eop_d   = end_q;
      state_d     = end_q ? IDLE : VID_FIRST;
    end
  end

  // State, pixel hold and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cur_q       <= '0;
      x_q         <= '0;
      end_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      x_q         <= x_d;
      end_q       <= end_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
    end
  end
endmodule

// File: tb/tb_stream_hsmooth.sv
// tb_stream_hsmooth: table-driven directed bench for stream_hsmooth with IMAGE_W=4
module tb_stream_hsmooth;
  logic clk = 1'b0;
  logic reset = 1'b1;
`ifdef HSMOOTH_BYPASS_EN
  logic bypass = 1'b0;
`endif
  always #5 clk = ~clk;

  stream_hsmooth_if sink_if();
  stream_hsmooth_if src_if();

  stream_hsmooth #(.IMAGE_W(11'd4)) dut (
    .clk(clk),
    .reset(reset),
`ifdef HSMOOTH_BYPASS_EN
    .bypass(bypass),
`endif
    .sink(sink_if),
    .source(src_if)
  );

  typedef struct {
    logic        sop;
    logic        eop;
    logic [23:0] d;
    logic        xsop;
    logic        xeop;
    logic [23:0] xd;
  } vec_t;

  vec_t v[$];
  int checks = 0;
  int errors = 0;

  task automatic add(input logic s, input logic e, input logic [23:0] d,
                     input logic xs, input logic xe, input logic [23:0] xd);
    v.push_back('{s, e, d, xs, xe, xd});
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, exp);
    end
  endtask

  // mode 0: source_ready held high; mode 1: source_ready toggles 1010...
  task automatic run(input string name, input int first, input int n, input int mode, output int stalls);
    int i, o, cyc;
    logic [25:0] got[$];
    i = 0; o = 0; cyc = 0; stalls = 0;
    while (o < n && cyc < 300) begin
      @(posedge clk); #1;
      if (i < n) begin
        sink_if.valid = 1'b1;
        sink_if.sop   = v[first+i].sop;
        sink_if.eop   = v[first+i].eop;
        sink_if.data  = v[first+i].d;
      end else begin
        sink_if.valid = 1'b0;
        sink_if.sop   = 1'b0;
        sink_if.eop   = 1'b0;
      end
      src_if.ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
      @(negedge clk);
      if (sink_if.valid && sink_if.ready) i++;
      else if (sink_if.valid) stalls++;
      if (src_if.valid && src_if.ready) begin
        got.push_back({src_if.sop, src_if.eop, src_if.data});
        o++;
      end
      cyc++;
    end
    @(posedge clk); #1;
    sink_if.valid = 1'b0;
    src_if.ready  = 1'b1;
    if (o < n) check($sformatf("%s_timeout_words", name), o, n);
    for (int k = 0; k < o; k++)
      check($sformatf("%s_w%0d", name, k), {6'b0, got[k]},
            {6'b0, v[first+k].xsop, v[first+k].xeop, v[first+k].xd});
  endtask

  int t_idle, t_vid, t_ctl, t_g, t_flat, t_short, t_mid, st;

  initial begin
    sink_if.valid = 1'b0;
    sink_if.sop   = 1'b0;
    sink_if.eop   = 1'b0;
    sink_if.data  = '0;
    src_if.ready  = 1'b1;

    t_idle = v.size();
    add(0, 0, 24'h55AA55, 0, 0, 24'h55AA55);
    t_vid = v.size();
    add(1, 0, 24'h000000, 1, 0, 24'h000000);
    add(0, 0, 24'h000000, 0, 0, 24'h000000);
    add(0, 0, 24'h000000, 0, 0, 24'h000000);
    add(0, 0, 24'hFF0000, 0, 0, 24'h400000);
    add(0, 1, 24'h000000, 0, 0, 24'h800000);
    v[t_vid+4].xeop = 1'b1; v[t_vid+4].xd = 24'h400000;
    v[t_vid+3].xd = 24'h800000; v[t_vid+2].xd = 24'h400000;
    t_ctl = v.size();
    add(1, 0, 24'h00000F, 1, 0, 24'h00000F);
    add(0, 0, 24'h123456, 0, 0, 24'h123456);
    add(0, 0, 24'hABCDEF, 0, 0, 24'hABCDEF);
    add(0, 1, 24'h777777, 0, 1, 24'h777777);
    t_g = v.size();
    add(1, 0, 24'h000010, 1, 0, 24'h000010);
    add(0, 0, 24'h0010FF, 0, 0, 24'h0014FF);
    add(0, 0, 24'h0020FF, 0, 0, 24'h0020FF);
    add(0, 0, 24'h0030FF, 0, 0, 24'h0030FF);
    add(0, 1, 24'h0040FF, 0, 1, 24'h003CFF);
    t_flat = v.size();
    add(1, 0, 24'h000000, 1, 0, 24'h000000);
    for (int k = 0; k < 8; k++) add(0, k == 7, 24'hFFFFFF, 0, k == 7, 24'hFFFFFF);
    t_short = v.size();
    add(1, 0, 24'h000000, 1, 0, 24'h000000);
    add(0, 0, 24'h0A0000, 0, 0, 24'h0F0000);
    add(0, 1, 24'h1E0000, 0, 1, 24'h190000);
    t_mid = v.size();
    add(1, 0, 24'h000000, 1, 0, 24'h000000);
    add(0, 0, 24'h0A0000, 0, 0, 24'h0F0000);
    add(0, 0, 24'h1E0000, 0, 1, 24'h190000);
    for (int k = 0; k < 5; k++) v.push_back(v[t_vid+k]);

    #1;
    check("rst_valid", {31'b0, src_if.valid}, 0);
    check("rst_data", {8'b0, src_if.data}, 0);
    check("rst_sop_eop", {30'b0, src_if.sop, src_if.eop}, 0);
    check("rst_sink_ready", {31'b0, sink_if.ready}, 1);
    @(posedge clk); #1 reset = 1'b0;

    run("idle_word", t_idle, 1, 0, st);
    run("video", t_vid, 5, 0, st);
    run("control", t_ctl, 4, 0, st);
    run("green", t_g, 5, 0, st);
    run("flat", t_flat, 9, 0, st);
    check("flat_bubbles", st, 1);
    run("video_bp", t_vid, 5, 1, st);
    run("short", t_short, 3, 0, st);
    run("sop_midline", t_mid, 8, 0, st);

    @(posedge clk); #1;
    sink_if.valid = 1'b1; sink_if.sop = 1'b1; sink_if.eop = 1'b0; sink_if.data = 24'h000000;
    @(posedge clk); #1;
    sink_if.sop = 1'b0; sink_if.data = 24'h0A0000;
    @(posedge clk); #1;
    sink_if.data = 24'h1E0000;
    @(posedge clk); #1;
    sink_if.valid = 1'b0;
    check("pre_reset_valid", {31'b0, src_if.valid}, 1);
    reset = 1'b1;
    #1;
    check("async_reset_valid", {31'b0, src_if.valid}, 0);
    check("async_reset_data", {8'b0, src_if.data}, 0);
    @(posedge clk); #1 reset = 1'b0;
    run("after_reset", t_vid, 5, 0, st);

`ifdef HSMOOTH_BYPASS_EN
    begin
      int t_byp;
      t_byp = v.size();
      for (int k = 0; k < 5; k++) add(v[t_vid+k].sop, v[t_vid+k].eop, v[t_vid+k].d,
                                      v[t_vid+k].sop, v[t_vid+k].eop, v[t_vid+k].d);
      bypass = 1'b1;
      run("bypass", t_byp, 5, 0, st);
      bypass = 1'b0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
